// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants and types for the SRAM row streamer
// Contents: row geometry, macro read latency, output buffer depth,
//           row/address/length types and the read FSM state encoding.
package mm_pkg;

    localparam int DATA_W     = 128;        // macro word = one matrix row
    localparam int ADDR_W     = 8;          // 256 rows
    localparam int LEN_W      = ADDR_W + 1; // row count 0..256
    localparam int READ_LAT   = 1;          // port-1 request to valid dout
    localparam int FIFO_DEPTH = 2;          // must cover READ_LAT + 1

    typedef logic [DATA_W-1:0] row_t;
    typedef logic [ADDR_W-1:0] row_addr_t;
    typedef logic [LEN_W-1:0]  row_len_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/mm_stream_fifo.sv
// rtl/mm_stream_fifo.sv - first-word-fall-through synchronous FIFO
// Ports: clk, reset (sync, active-high)
//        i_push/i_din   write side
//        i_pop          consume head (only meaningful while o_valid)
//        o_dout/o_valid head word; a push into an empty FIFO is visible at once
//        o_count        stored entries
module mm_stream_fifo
    import mm_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = DATA_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_store;
    logic             w_take;

    assign w_empty = (r_count == '0);
    // A word pushed into an empty FIFO and popped in the same cycle
    // passes straight through and is never stored.
    assign w_store = i_push && !(w_empty && i_pop);
    assign w_take  = i_pop && !w_empty;
    assign o_valid = !w_empty || i_push;
    assign o_dout  = w_empty ? i_din : r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_take) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_store, w_take})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wptr] <= i_din;
        end
    end

endmodule

// File: rtl/mm_sram_row_streamer.sv
// rtl/mm_sram_row_streamer.sv - row write port and streaming row reader for a dual-port SRAM macro
// Ports: clk, reset (sync, active-high)
//        wr_valid/wr_ready/wr_addr/wr_data          row writes -> macro port 0
//        rd_start/rd_base/rd_len/rd_busy/rd_done    stream command and status
//        out_valid/out_ready/out_data/out_last      row stream with backpressure
//        sram_csb0/web0/addr0/din0                  macro port 0 (active-low selects)
//        sram_csb1/addr1/dout1                      macro port 1 (read-only)
module mm_sram_row_streamer
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W:0]   rd_len,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [DATA_W-1:0] sram_din0,
    output logic              sram_csb1,
    output logic [ADDR_W-1:0] sram_addr1,
    input  logic [DATA_W-1:0] sram_dout1
);

    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_CNT_W = $clog2(READ_LAT + 2);

    rd_state_t            r_state;
    rd_state_t            w_state_nxt;
    row_addr_t            r_base;
    row_len_t             r_len;
    row_len_t             r_issued;
    row_len_t             r_delivered;
    logic [READ_LAT-1:0]  r_lat_sr;
    logic [LAT_CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0]     w_fifo_count;
    row_addr_t            w_rd_addr;
    logic                 w_wr_fire;
    logic                 w_start;
    logic                 w_collide;
    logic                 w_credit;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_final;

    // Write path: purely combinational pass-through to macro port 0.
    assign wr_ready   = !reset;
    assign w_wr_fire  = wr_valid && wr_ready;
    assign sram_csb0  = !w_wr_fire;
    assign sram_web0  = !w_wr_fire;
    assign sram_addr0 = wr_addr;
    assign sram_din0  = wr_data;

    assign w_start   = (r_state == IDLE) && rd_start && (rd_len != '0);
    assign w_rd_addr = r_base + r_issued[ADDR_W-1:0];   // wraps 255 -> 0

    // A read of the row being written this cycle would return stale data,
    // so it waits one cycle for the write to land.
    assign w_collide = w_wr_fire && (wr_addr == w_rd_addr);

    // Every stored entry plus every in-flight read holds a FIFO slot; the
    // entry leaving this cycle frees its slot early so a continuously
    // ready consumer gets one beat per cycle.
    assign w_credit = (int'(w_fifo_count) + int'(r_inflight)) < (FIFO_DEPTH + int'(w_pop));

    assign w_issue    = (r_state == ISSUE) && (r_issued != r_len) && w_credit && !w_collide;
    assign sram_csb1  = !w_issue;
    assign sram_addr1 = w_rd_addr;

    assign w_push  = r_lat_sr[READ_LAT-1];
    assign w_pop   = out_valid && out_ready;
    assign w_final = (r_delivered == r_len - 1'b1);

    assign out_last = out_valid && w_final;
    assign rd_done  = w_pop && w_final && (r_state == DRAIN);
    assign rd_busy  = (r_state != IDLE);

    mm_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (sram_dout1),
        .i_pop   (w_pop),
        .o_dout  (out_data),
        .o_valid (out_valid),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = ISSUE;
            ISSUE:   if (w_issue && (r_issued + 1'b1 == r_len)) w_state_nxt = DRAIN;
            DRAIN:   if (rd_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_lat_sr    <= '0;
            r_inflight  <= '0;
        end else begin
            if (w_start) begin
                r_base      <= rd_base;
                r_len       <= rd_len;
                r_issued    <= '0;
                r_delivered <= '0;
            end else begin
                if (w_issue) r_issued    <= r_issued + 1'b1;
                if (w_pop)   r_delivered <= r_delivered + 1'b1;
            end
            r_lat_sr   <= (r_lat_sr << 1) | READ_LAT'(w_issue);
            r_inflight <= r_inflight + LAT_CNT_W'(w_issue) - LAT_CNT_W'(w_push);
        end
    end

endmodule

// File: tb/tb_mm_sram_row_streamer.sv
// tb/tb_mm_sram_row_streamer.sv - self-checking bench for mm_sram_row_streamer
module tb_mm_sram_row_streamer;

    logic         clk;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [7:0]   wr_addr;
    logic [127:0] wr_data;
    logic         rd_start;
    logic [7:0]   rd_base;
    logic [8:0]   rd_len;
    logic         rd_busy;
    logic         rd_done;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         sram_csb0;
    logic         sram_web0;
    logic [7:0]   sram_addr0;
    logic [127:0] sram_din0;
    logic         sram_csb1;
    logic [7:0]   sram_addr1;
    logic [127:0] sram_dout1;

    mm_sram_row_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_start   (rd_start),
        .rd_base    (rd_base),
        .rd_len     (rd_len),
        .rd_busy    (rd_busy),
        .rd_done    (rd_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: port 0 write, port 1 registered read (latency 1).
    logic [127:0] macro_mem [256];
    always @(posedge clk) begin
        if (!sram_csb0 && !sram_web0) macro_mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= macro_mem[sram_addr1];
    end

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         mode;       // 0 ready, 1 ready pattern 1,0,0,1, 2 stalled + start while busy
        int         exp_first;  // cycles after the rd_start cycle minus one
    } vec_t;

    logic [127:0] shadow [256];
    exp_t         exp_q[$];
    logic [7:0]   addr_q[$];
    exp_t         mon_e;
    int           total = 0;
    int           bad = 0;
    int           beats = 0;
    int           done_cnt = 0;
    int           iss_tot = 0;
    int           del_tot = 0;
    int           max_out = 0;
    logic         stall_prev = 1'b0;
    logic [127:0] prev_data = '0;
    logic [3:0]   ready_pat;
    vec_t         vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor samples just before the edge that performs the handshake.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
            iss_tot    = 0;
            del_tot    = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (!sram_csb1) begin
                addr_q.push_back(sram_addr1);
                iss_tot++;
            end
            if (out_valid && out_ready) begin
                beats++;
                del_tot++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat act=%h exp=none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", out_data, mon_e.data);
                    check("beat_last", out_last, mon_e.last);
                    check("done_pulse", rd_done, mon_e.last);
                end
            end else if (rd_done) begin
                total++;
                bad++;
                $display("FAIL stray_done act=1 exp=0");
            end
            if (rd_done) done_cnt++;
            if (iss_tot - del_tot > max_out) max_out = iss_tot - del_tot;
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic run_stream(input logic [7:0] base, input logic [8:0] len,
                              input int mode, input int exp_first);
        exp_t e;
        int   first;
        int   errs;
        int   d0;
        int   c;
        addr_q.delete();
        max_out = 0;
        d0 = done_cnt;
        for (int i = 0; i < int'(len); i++) begin
            e.data = shadow[8'(int'(base) + i)];
            e.last = (i == int'(len) - 1);
            exp_q.push_back(e);
        end
        first = -1;
        for (c = 0; c < int'(len) * 6 + 20; c++) begin
            if (c == 0) begin
                rd_start = 1'b1;
                rd_base  = base;
                rd_len   = len;
            end else if (mode == 2 && c == 3) begin
                rd_start = 1'b1;
                rd_base  = 8'd50;
                rd_len   = 9'd3;
            end else begin
                rd_start = 1'b0;
            end
            if (mode == 1)      out_ready = ready_pat[c % 4];
            else if (mode == 2) out_ready = (c >= 6);
            else                out_ready = 1'b1;
            tick();
            if (c == 0) check("busy_start", rd_busy, 1);
            if (first < 0 && out_valid) first = c;
            if (exp_q.size() == 0) break;
        end
        rd_start = 1'b0;
        check("stream_left", exp_q.size(), 0);
        check("busy_end", rd_busy, 0);
        check("first_valid", first, exp_first);
        tick();
        check("done_count", done_cnt - d0, 1);
        check("issue_count", addr_q.size(), len);
        errs = 0;
        foreach (addr_q[i]) if (addr_q[i] != 8'(int'(base) + i)) errs++;
        check("issue_addr", errs, 0);
        check("max_outstanding", max_out <= 2, 1);
        exp_q.delete();
    endtask

    initial begin
        exp_t e;
        int   b0;
        int   d0;
        int   k;
        ready_pat = 4'b1001;
        vecs[0] = '{base: 8'd0,   len: 9'd8,   mode: 0, exp_first: 1};
        vecs[1] = '{base: 8'd0,   len: 9'd8,   mode: 1, exp_first: 1};
        vecs[2] = '{base: 8'd254, len: 9'd4,   mode: 0, exp_first: 1};
        vecs[3] = '{base: 8'd100, len: 9'd1,   mode: 0, exp_first: 1};
        vecs[4] = '{base: 8'd10,  len: 9'd4,   mode: 2, exp_first: 1};
        vecs[5] = '{base: 8'd200, len: 9'd256, mode: 0, exp_first: 1};

        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_done", rd_done, 0);
        check("rst_csb0", sram_csb0, 1);
        check("rst_web0", sram_web0, 1);
        check("rst_csb1", sram_csb1, 1);
        reset = 1'b0;
        tick();

        // Fill every row; rows 0..7 carry the A5 pattern.
        for (int a = 0; a < 256; a++) begin
            wr_valid = 1'b1;
            wr_addr  = 8'(a);
            wr_data  = (a < 8) ? ({16{8'hA5}} ^ 128'(a))
                               : {$urandom, $urandom, $urandom, $urandom};
            shadow[a] = wr_data;
            #1;
            if (a < 8) begin
                check("wr_csb0", sram_csb0, 0);
                check("wr_web0", sram_web0, 0);
                check("wr_addr0", sram_addr0, a);
                check("wr_din0", sram_din0, shadow[a]);
            end
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("idle_csb0", sram_csb0, 1);

        foreach (vecs[i]) run_stream(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].exp_first);

        // Zero-length start is ignored.
        addr_q.delete();
        d0 = done_cnt;
        rd_start = 1'b1; rd_base = 8'd5; rd_len = 9'd0;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("len0_busy", rd_busy, 0);
        check("len0_issues", addr_q.size(), 0);
        check("len0_done", done_cnt - d0, 0);
        check("len0_valid", out_valid, 0);

        // Write row 3 in the cycle its read would issue.
        shadow[3] = 128'h1234;
        e.data = 128'h1234;
        e.last = 1'b1;
        exp_q.push_back(e);
        out_ready = 1'b1;
        rd_start = 1'b1; rd_base = 8'd3; rd_len = 9'd1;
        tick();
        rd_start = 1'b0;
        wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 128'h1234;
        #1;
        check("coll_defer_csb1", sram_csb1, 1);
        check("coll_wr_csb0", sram_csb0, 0);
        tick();
        wr_valid = 1'b0;
        #1;
        check("coll_issue_csb1", sram_csb1, 0);
        check("coll_issue_addr", sram_addr1, 3);
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        check("coll_left", exp_q.size(), 0);
        tick();
        check("coll_busy", rd_busy, 0);

        // Reset while the third beat of a len=8 stream is presented.
        for (int i = 0; i < 8; i++) begin
            e.data = shadow[i];
            e.last = (i == 7);
            exp_q.push_back(e);
        end
        b0 = beats;
        d0 = done_cnt;
        out_ready = 1'b1;
        rd_start = 1'b1; rd_base = 8'd0; rd_len = 9'd8;
        tick();
        rd_start = 1'b0;
        k = 0;
        while (beats - b0 < 2 && k < 40) begin
            tick();
            k++;
        end
        check("rst_mid_beats", beats - b0, 2);
        check("rst_mid_beat3_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_wr_ready", wr_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", rd_busy, 0);
        check("rst_mid_csb1", sram_csb1, 1);
        check("rst_mid_last", out_last, 0);
        exp_q.delete();
        tick();
        check("rst_mid_no_done", done_cnt - d0, 0);
        run_stream(8'd0, 9'd8, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/mm_sram_row_streamer.md
Name: mm_sram_row_streamer

Overview:
- Controller/streamer between the matrix-multiply datapath and the 128x256 dual-port SRAM macro (port 0 read-write, port 1 read-only).
- Accepts row writes and drives macro port 0.
- On command, reads a contiguous run of rows through macro port 1 and presents them as a valid/ready stream with full backpressure.
- Hides macro read latency with a small credit-controlled output FIFO.
- Macro clk0/clk1 are tied to clk at the top level.

Parameters:
- DATA_W, 128, row width in bits (matches the macro word).
- ADDR_W, 8, row address width (256 rows).
- READ_LAT, 1, cycles from port-1 request to valid sram_dout1.
- FIFO_DEPTH, 2, output buffer entries; must be >= READ_LAT+1.

Ports:
- clk  in  1  single clock for the block and both macro ports.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when high.
- wr_addr  in  ADDR_W  write row address.
- wr_data  in  DATA_W  write row data.
- rd_start  in  1  start-stream command pulse.
- rd_base  in  ADDR_W  first row of the stream.
- rd_len  in  ADDR_W+1  row count, 0..256.
- rd_busy  out  1  stream in progress.
- rd_done  out  1  one-cycle pulse on the final beat handshake.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_W  stream row.
- out_last  out  1  high with the final beat.
- sram_csb0  out  1  macro port-0 chip select, active-low.
- sram_web0  out  1  macro port-0 write enable, active-low.
- sram_addr0  out  ADDR_W  macro port-0 address.
- sram_din0  out  DATA_W  macro port-0 write data.
- sram_csb1  out  1  macro port-1 chip select, active-low.
- sram_addr1  out  ADDR_W  macro port-1 address.
- sram_dout1  in  DATA_W  macro port-1 read data.

Behaviour:
- Reset values (cycle after reset is sampled high): out_valid=0, out_last=0, rd_busy=0, rd_done=0, sram_csb0=1, sram_web0=1, sram_csb1=1, FIFO empty, in-flight read tracking cleared, state IDLE. wr_ready=0 while reset is high.
- Write path:
  - wr_ready = !reset.
  - Each wr_valid&&wr_ready cycle drives csb0=0, web0=0, addr0=wr_addr, din0=wr_data combinationally from the inputs in that same cycle.
  - Otherwise csb0=1, web0=1.
  - Writes are accepted in every state.
- Read FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on rd_start with rd_len!=0. Latch rd_base/rd_len; clear issued and delivered counters; rd_busy=1.
  - rd_start with rd_len==0 is ignored. rd_start while rd_busy is ignored.
  - ISSUE: issue a read (csb1=0, addr1=base+issued, mod 256) in any cycle where fifo_count + inflight < FIFO_DEPTH, subject to the collision rule below.
  - ISSUE -> DRAIN when issued reaches len.
  - DRAIN -> IDLE on the handshake of the final beat; rd_done pulses in that same cycle and rd_busy falls the next cycle.
- Read latency: a request issued at cycle t pushes sram_dout1 into the FIFO at t+READ_LAT, tracked by a READ_LAT-deep valid shift register. Minimum latency from rd_start to first out_valid is 1+READ_LAT cycles.
- Throughput: with out_ready held high, one beat per cycle sustained.
- Collision: if a read issue would target the row being written the same cycle, the read is deferred one cycle, so the stream returns the newly written data.
- Address wrap: 255 -> 0. rd_len=256 reads every row exactly once.
- out_data and out_valid come from the FIFO head. out_last = out_valid && (delivered == len-1). Data must stay stable while out_valid && !out_ready.
- FIFO never overflows: the credit rule guarantees space for every in-flight read.
- Reset mid-stream: FIFO, in-flight reads and counters are discarded; no rd_done pulse; macro selects are deasserted the next cycle.

Decomposition:
- Shared package mm_pkg: DATA_W, ADDR_W, READ_LAT constants; typedef row_t (logic [DATA_W-1:0]); typedef row_addr_t; enum rd_state_t {IDLE, ISSUE, DRAIN}.
- One sub-module: mm_stream_fifo (parameterised depth/width synchronous FIFO; push/pop/count; synchronous active-high reset).

Test Plan:
- Write rows 0..7 with data = 0xA5..A5 XOR addr, then rd_start base=0 len=8 with out_ready=1 -> eight beats in order, first out_valid 2 cycles after rd_start, out_last and rd_done on beat 7 only.
- Same stream with out_ready toggling 1,0,0,1 -> no beat dropped or duplicated, out_data stable while stalled, FIFO never exceeds 2 entries, never more than 2 reads outstanding.
- rd_base=254, rd_len=4 -> addresses 254, 255, 0, 1 issued; data matches those rows.
- rd_len=0, and rd_start while busy -> no state change, no sram_csb1 activity, no rd_done.
- Write row 3 with 0x1234 in the same cycle the read of row 3 would issue -> read deferred one cycle, beat returns 0x1234.
- Assert reset during the third beat of a len=8 stream -> next cycle out_valid=0, rd_busy=0, csb1=1; a new stream afterwards behaves normally.
